// File: rtl/yukle_sakla_birimi_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and access size decode.
package ys_paket;

   localparam logic [2:0] F3_BAYT    = 3'b000;
   localparam logic [2:0] F3_YARIM   = 3'b001;
   localparam logic [2:0] F3_KELIME  = 3'b010;
   localparam logic [2:0] F3_BAYT_U  = 3'b100;
   localparam logic [2:0] F3_YARIM_U = 3'b101;

   typedef enum logic [1:0] {
      BOSTA = 2'd0,
      OKU   = 2'd1,
      YAZ   = 2'd2,
      TAMAM = 2'd3
   } durum_t;

   typedef enum logic [1:0] {
      BOYUT_BAYT   = 2'd0,
      BOYUT_YARIM  = 2'd1,
      BOYUT_KELIME = 2'd2
   } boyut_t;

   // Every code that is not a byte or half access is treated as a full word.
   function automatic boyut_t boyut_coz(input logic [2:0] f3);
      boyut_t b;
      case (f3)
         F3_BAYT, F3_BAYT_U:   b = BOYUT_BAYT;
         F3_YARIM, F3_YARIM_U: b = BOYUT_YARIM;
         F3_KELIME:            b = BOYUT_KELIME;
         default:              b = BOYUT_KELIME;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/yukle_sakla_birimi_bayt_hizalayici.sv
// Lane extraction with sign/zero extension for loads and lane merge for stores.
module bayt_hizalayici
   import ys_paket::*;
(
   input  boyut_t      i_boyut,
   input  logic        i_isaretsiz,
   input  logic [1:0]  i_serit,
   input  logic [31:0] i_kelime,
   input  logic [31:0] i_veri,
   output logic [31:0] o_yuklenen,
   output logic [31:0] o_birlesik
);

   logic [7:0]  w_bayt;
   logic [15:0] w_yarim;

   assign w_bayt  = i_kelime[{i_serit, 3'b000} +: 8];
   assign w_yarim = i_serit[1] ? i_kelime[31:16] : i_kelime[15:0];

   always_comb begin
      o_yuklenen = i_kelime;
      o_birlesik = i_veri;
      case (i_boyut)
         BOYUT_BAYT: begin
            o_yuklenen = {{24{w_bayt[7] & ~i_isaretsiz}}, w_bayt};
            o_birlesik = i_kelime;
            o_birlesik[{i_serit, 3'b000} +: 8] = i_veri[7:0];
         end
         BOYUT_YARIM: begin
            o_yuklenen = {{16{w_yarim[15] & ~i_isaretsiz}}, w_yarim};
            o_birlesik = i_kelime;
            if (i_serit[1]) begin
               o_birlesik[31:16] = i_veri[15:0];
            end else begin
               o_birlesik[15:0] = i_veri[15:0];
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/yukle_sakla_birimi.sv
// Byte-addressed load/store unit over a word-addressed memory with read-modify-write sub-word stores.
// Optional macro YS_HIZASIZ_HATA_EN: misaligned half/word accesses complete at once with hizasiz_hata.
module yukle_sakla_birimi
   import ys_paket::*;
#(
   parameter int unsigned ADRES_GENISLIGI = 8
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        istek_gecerli,
   output logic        istek_hazir,
   input  logic        istek_yaz,
   input  logic [2:0]  istek_funct3,
   input  logic [31:0] istek_adres,
   input  logic [31:0] istek_veri,
   output logic        sonuc_gecerli,
   output logic [31:0] sonuc_veri,
   output logic        hizasiz_hata,
   output logic [31:0] bellek_adres,
   output logic [31:0] bellek_veri_girisi,
   output logic        bellege_yaz,
   input  logic [31:0] bellek_veri_cikisi
);

   localparam int unsigned VERI_G = 32;

   durum_t             r_durum;
   durum_t             w_sonraki;
   logic               r_istek_hazir;
   logic               r_sonuc_gecerli;
   logic               r_bellege_yaz;
   logic               r_yaz;
   boyut_t             r_boyut;
   logic               r_isaretsiz;
   logic [1:0]         r_serit;
   logic [VERI_G-1:0]  r_veri;
   logic [VERI_G-1:0]  r_bellek_adres;
   logic [VERI_G-1:0]  r_okunan;
   logic [VERI_G-1:0]  r_sonuc;

   logic               w_kabul;
   boyut_t             w_boyut;
   logic [1:0]         w_serit;
   logic               w_hata_yolu;
   logic [VERI_G-1:0]  w_kelime;
   logic [VERI_G-1:0]  w_yuklenen;
   logic [VERI_G-1:0]  w_birlesik;
   logic               w_unused_adres;

   assign w_kabul        = istek_gecerli & (r_durum == BOSTA);
   assign w_boyut        = boyut_coz(istek_funct3);
   assign w_unused_adres = ^istek_adres[31:ADRES_GENISLIGI+2];

   // Low address bits a size cannot use are dropped, so a misaligned access hits the aligned lane.
   always_comb begin
      w_serit = 2'b00;
      case (w_boyut)
         BOYUT_BAYT:  w_serit = istek_adres[1:0];
         BOYUT_YARIM: w_serit = {istek_adres[1], 1'b0};
         default:     w_serit = 2'b00;
      endcase
   end

`ifdef YS_HIZASIZ_HATA_EN
   assign w_hata_yolu = ((w_boyut == BOYUT_YARIM) && istek_adres[0]) ||
                        ((w_boyut == BOYUT_KELIME) && (istek_adres[1:0] != 2'b00));
`else
   assign w_hata_yolu = 1'b0;
`endif

   // Live memory word while reading; the captured word while writing back.
   assign w_kelime = (r_durum == OKU) ? bellek_veri_cikisi : r_okunan;

   bayt_hizalayici u_hizalayici (
      .i_boyut     (r_boyut),
      .i_isaretsiz (r_isaretsiz),
      .i_serit     (r_serit),
      .i_kelime    (w_kelime),
      .i_veri      (r_veri),
      .o_yuklenen  (w_yuklenen),
      .o_birlesik  (w_birlesik)
   );

   always_comb begin
      w_sonraki = r_durum;
      case (r_durum)
         BOSTA: begin
            if (istek_gecerli) begin
               if (w_hata_yolu) begin
                  w_sonraki = TAMAM;
               end else if (istek_yaz && (w_boyut == BOYUT_KELIME)) begin
                  w_sonraki = YAZ;
               end else begin
                  w_sonraki = OKU;
               end
            end
         end
         OKU:     w_sonraki = r_yaz ? YAZ : TAMAM;
         YAZ:     w_sonraki = TAMAM;
         TAMAM:   w_sonraki = BOSTA;
         default: w_sonraki = BOSTA;
      endcase
   end

`ifdef YS_HIZASIZ_HATA_EN
   logic r_hizasiz_hata;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_durum         <= BOSTA;
         r_istek_hazir   <= 1'b1;
         r_sonuc_gecerli <= 1'b0;
         r_bellege_yaz   <= 1'b0;
         r_yaz           <= 1'b0;
         r_boyut         <= BOYUT_BAYT;
         r_isaretsiz     <= 1'b0;
         r_serit         <= 2'b00;
         r_veri          <= '0;
         r_bellek_adres  <= '0;
         r_okunan        <= '0;
         r_sonuc         <= '0;
`ifdef YS_HIZASIZ_HATA_EN
         r_hizasiz_hata  <= 1'b0;
`endif
      end else begin
         r_durum         <= w_sonraki;
         r_istek_hazir   <= (w_sonraki == BOSTA);
         r_sonuc_gecerli <= (w_sonraki == TAMAM);
         r_bellege_yaz   <= (w_sonraki == YAZ);
`ifdef YS_HIZASIZ_HATA_EN
         r_hizasiz_hata  <= (w_sonraki == TAMAM) && (r_durum == BOSTA);
`endif
         if (w_kabul) begin
            r_yaz          <= istek_yaz;
            r_boyut        <= w_boyut;
            r_isaretsiz    <= istek_funct3[2];
            r_serit        <= w_serit;
            r_veri         <= istek_veri;
            r_bellek_adres <= VERI_G'(istek_adres[ADRES_GENISLIGI+1:2]);
         end
         if (r_durum == OKU) begin
            r_okunan <= bellek_veri_cikisi;
         end
         // Stores and error completions report zero; the value holds until the next completion.
         if (w_sonraki == TAMAM) begin
            r_sonuc <= (r_durum == OKU) ? w_yuklenen : '0;
         end
      end
   end

   assign istek_hazir        = r_istek_hazir;
   assign sonuc_gecerli      = r_sonuc_gecerli;
   assign sonuc_veri         = r_sonuc;
   assign bellek_adres       = r_bellek_adres;
   assign bellege_yaz        = r_bellege_yaz;
   assign bellek_veri_girisi = r_bellege_yaz ? w_birlesik : '0;
`ifdef YS_HIZASIZ_HATA_EN
   assign hizasiz_hata       = r_hizasiz_hata;
`else
   assign hizasiz_hata       = 1'b0;
`endif

endmodule

// File: tb/tb_yukle_sakla_birimi.sv
// Scoreboard bench for yukle_sakla_birimi: directed cases, a mid-operation reset, then random traffic.
// Honours YS_HIZASIZ_HATA_EN in its reference model.
module tb_yukle_sakla_birimi;

   typedef struct {
      logic [31:0] veri;
      logic        hata;
      int          cyc;
   } sonuc_bek_t;

   typedef struct {
      logic [31:0] adres;
      logic [31:0] veri;
      int          cyc;
   } yazma_bek_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        istek_gecerli;
   logic        istek_hazir;
   logic        istek_yaz;
   logic [2:0]  istek_funct3;
   logic [31:0] istek_adres;
   logic [31:0] istek_veri;
   logic        sonuc_gecerli;
   logic [31:0] sonuc_veri;
   logic        hizasiz_hata;
   logic [31:0] bellek_adres;
   logic [31:0] bellek_veri_girisi;
   logic        bellege_yaz;
   logic [31:0] bellek_veri_cikisi;

   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];
   sonuc_bek_t  q_sonuc [$];
   yazma_bek_t  q_yaz   [$];
   sonuc_bek_t  bs;
   yazma_bek_t  by;
   int          n_top   = 0;
   int          n_gecen = 0;
   int          cyc     = 0;

   yukle_sakla_birimi dut (
      .clk                (clk),
      .rst                (rst),
      .istek_gecerli      (istek_gecerli),
      .istek_hazir        (istek_hazir),
      .istek_yaz          (istek_yaz),
      .istek_funct3       (istek_funct3),
      .istek_adres        (istek_adres),
      .istek_veri         (istek_veri),
      .sonuc_gecerli      (sonuc_gecerli),
      .sonuc_veri         (sonuc_veri),
      .hizasiz_hata       (hizasiz_hata),
      .bellek_adres       (bellek_adres),
      .bellek_veri_girisi (bellek_veri_girisi),
      .bellege_yaz        (bellege_yaz),
      .bellek_veri_cikisi (bellek_veri_cikisi)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] baslangic_kelimesi(input int i);
      if (i == 3) return 32'h8899AABB;
      return (32'(i) * 32'h01010101) ^ 32'h5A3C96E1;
   endfunction

   // Data memory with combinational read; reset reloads its initial image.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= baslangic_kelimesi(i);
      end else if (bellege_yaz) begin
         mem[bellek_adres[7:0]] <= bellek_veri_girisi;
      end
   end
   assign bellek_veri_cikisi = mem[bellek_adres[7:0]];

   task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
      n_top++;
      if (gercek === beklenen) n_gecen++;
      else $display("FAIL %s: actual=%h required=%h t=%0t", ad, gercek, beklenen, $time);
   endtask

   // Reference model: RISC-V sub-word semantics with shifts and masks.
   function automatic logic [31:0] model_yukle(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] v;
      int kay;
      if (f3[1]) return w;
      if (f3[0]) begin
         kay = a[1] ? 16 : 0;
         v = (w >> kay) & 32'h0000FFFF;
         if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
      end else begin
         kay = 8 * int'(a[1:0]);
         v = (w >> kay) & 32'h000000FF;
         if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
      end
      return v;
   endfunction

   function automatic logic [31:0] model_yaz(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] maske;
      int kay;
      if (f3[1]) return d;
      if (f3[0]) begin
         kay = a[1] ? 16 : 0;
         maske = 32'h0000FFFF << kay;
      end else begin
         kay = 8 * int'(a[1:0]);
         maske = 32'h000000FF << kay;
      end
      return (w & ~maske) | ((d << kay) & maske);
   endfunction

   // Monitor: pops expectations whenever the unit completes or writes.
   always @(negedge clk) begin
      if (!rst) begin
         if (sonuc_gecerli) begin
            if (q_sonuc.size() == 0) begin
               kontrol("beklenmeyen_sonuc", 32'(sonuc_gecerli), 32'd0);
            end else begin
               bs = q_sonuc.pop_front();
               kontrol("sonuc_veri", sonuc_veri, bs.veri);
               kontrol("hizasiz_hata", 32'(hizasiz_hata), 32'(bs.hata));
               kontrol("sonuc_gecikme", 32'(cyc), 32'(bs.cyc));
            end
         end
         if (bellege_yaz) begin
            if (q_yaz.size() == 0) begin
               kontrol("beklenmeyen_yazma", 32'(bellege_yaz), 32'd0);
            end else begin
               by = q_yaz.pop_front();
               kontrol("yazma_adres", bellek_adres, by.adres);
               kontrol("yazma_veri", bellek_veri_girisi, by.veri);
               kontrol("yazma_gecikme", 32'(cyc), 32'(by.cyc));
            end
         end
      end
   end

   // Issues one request at a negedge, queues its expectations and keeps inputs noisy while busy.
   task automatic istek(input logic yaz, input logic [2:0] f3, input logic [31:0] adres, input logic [31:0] veri,
                        input logic [31:0] bek_veri, input logic bek_hata, input int gec,
                        input logic yazma, input logic [31:0] bek_yaz, input int yaz_gec);
      int bekle = 0;
      int mesgul = 0;
      while (!istek_hazir && bekle < 20) begin
         @(negedge clk);
         bekle++;
      end
      if (!istek_hazir) begin
         kontrol("hazir_zaman_asimi", 32'(istek_hazir), 32'd1);
         return;
      end
      istek_gecerli = 1'b1;
      istek_yaz     = yaz;
      istek_funct3  = f3;
      istek_adres   = adres;
      istek_veri    = veri;
      q_sonuc.push_back('{bek_veri, bek_hata, cyc + gec});
      if (yazma) q_yaz.push_back('{32'(adres[9:2]), bek_yaz, cyc + yaz_gec});
      @(negedge clk);
      while (!istek_hazir && mesgul < 20) begin
         mesgul++;
         istek_gecerli = 1'($urandom);
         istek_yaz     = 1'($urandom);
         istek_funct3  = 3'($urandom);
         istek_adres   = $urandom;
         istek_veri    = $urandom;
         @(negedge clk);
      end
      istek_gecerli = 1'b0;
      kontrol("mesgul_sure", 32'(mesgul), 32'(gec));
   endtask

   task automatic rastgele_islem();
      logic        yaz;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] yeni;
      logic        hizasiz;
      int          idx;
      int          boyut;
      yaz   = 1'($urandom);
      f3    = 3'($urandom);
      a     = $urandom & 32'hFFFFF03F;
      d     = $urandom;
      idx   = int'(a[9:2]);
      boyut = f3[1] ? 4 : (f3[0] ? 2 : 1);
`ifdef YS_HIZASIZ_HATA_EN
      hizasiz = ((boyut == 2) && a[0]) || ((boyut == 4) && (a[1:0] != 2'b00));
`else
      hizasiz = 1'b0;
`endif
      if (hizasiz) begin
         istek(yaz, f3, a, d, 32'd0, 1'b1, 1, 1'b0, 32'd0, 0);
      end else if (!yaz) begin
         istek(1'b0, f3, a, d, model_yukle(ref_mem[idx], f3, a), 1'b0, 2, 1'b0, 32'd0, 0);
      end else begin
         yeni = model_yaz(ref_mem[idx], f3, a, d);
         ref_mem[idx] = yeni;
         istek(1'b1, f3, a, d, 32'd0, 1'b0, (boyut == 4) ? 2 : 3, 1'b1, yeni, (boyut == 4) ? 1 : 2);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst           = 1'b1;
      istek_gecerli = 1'b0;
      istek_yaz     = 1'b0;
      istek_funct3  = 3'b000;
      istek_adres   = 32'd0;
      istek_veri    = 32'd0;
      for (int i = 0; i < 256; i++) ref_mem[i] = baslangic_kelimesi(i);
      repeat (3) @(negedge clk);
      kontrol("reset_istek_hazir", 32'(istek_hazir), 32'd1);
      kontrol("reset_sonuc_gecerli", 32'(sonuc_gecerli), 32'd0);
      kontrol("reset_sonuc_veri", sonuc_veri, 32'd0);
      kontrol("reset_hizasiz_hata", 32'(hizasiz_hata), 32'd0);
      kontrol("reset_bellek_adres", bellek_adres, 32'd0);
      kontrol("reset_bellek_veri_girisi", bellek_veri_girisi, 32'd0);
      kontrol("reset_bellege_yaz", 32'(bellege_yaz), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed loads from word 3 = 0x8899AABB
      istek(1'b0, 3'b000, 32'h0000000D, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 1'b0, 32'd0, 0);
      istek(1'b0, 3'b100, 32'h0000000D, 32'h0, 32'h000000AA, 1'b0, 2, 1'b0, 32'd0, 0);
      istek(1'b0, 3'b001, 32'h0000000E, 32'h0, 32'hFFFF8899, 1'b0, 2, 1'b0, 32'd0, 0);
      istek(1'b0, 3'b101, 32'h0000000E, 32'h0, 32'h00008899, 1'b0, 2, 1'b0, 32'd0, 0);
      // Sub-word store then word store and read-back
      istek(1'b1, 3'b000, 32'h0000000C, 32'h12345677, 32'd0, 1'b0, 3, 1'b1, 32'h8899AA77, 2);
      ref_mem[3] = 32'h8899AA77;
      istek(1'b1, 3'b010, 32'h00000010, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1'b1, 32'hDEADBEEF, 1);
      ref_mem[4] = 32'hDEADBEEF;
      istek(1'b0, 3'b010, 32'h00000010, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0, 32'd0, 0);
      // Misaligned word load
`ifdef YS_HIZASIZ_HATA_EN
      istek(1'b0, 3'b010, 32'h0000000E, 32'h0, 32'd0, 1'b1, 1, 1'b0, 32'd0, 0);
`else
      istek(1'b0, 3'b010, 32'h0000000E, 32'h0, 32'h8899AA77, 1'b0, 2, 1'b0, 32'd0, 0);
`endif
      // Address wrap above the word index
      istek(1'b0, 3'b010, 32'hFFFFFC10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0, 32'd0, 0);

      // Reset while a half store is in its read step
      istek_gecerli = 1'b1;
      istek_yaz     = 1'b1;
      istek_funct3  = 3'b001;
      istek_adres   = 32'h00000020;
      istek_veri    = $urandom;
      @(posedge clk);
      #1;
      istek_gecerli = 1'b0;
      kontrol("oku_bellege_yaz", 32'(bellege_yaz), 32'd0);
      kontrol("oku_istek_hazir", 32'(istek_hazir), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      kontrol("arst_istek_hazir", 32'(istek_hazir), 32'd1);
      kontrol("arst_bellege_yaz", 32'(bellege_yaz), 32'd0);
      kontrol("arst_sonuc_gecerli", 32'(sonuc_gecerli), 32'd0);
      kontrol("arst_bellek_adres", bellek_adres, 32'd0);
      kontrol("arst_bellek_veri_girisi", bellek_veri_girisi, 32'd0);
      kontrol("arst_sonuc_veri", sonuc_veri, 32'd0);
      @(negedge clk);
      kontrol("rst_bellege_yaz_1", 32'(bellege_yaz), 32'd0);
      @(negedge clk);
      kontrol("rst_bellege_yaz_2", 32'(bellege_yaz), 32'd0);
      rst = 1'b0;
      q_sonuc.delete();
      q_yaz.delete();
      for (int i = 0; i < 256; i++) ref_mem[i] = baslangic_kelimesi(i);
      @(negedge clk);
      kontrol("rst_sonrasi_hazir", 32'(istek_hazir), 32'd1);
      istek(1'b0, 3'b010, 32'h00000010, 32'h0, baslangic_kelimesi(4), 1'b0, 2, 1'b0, 32'd0, 0);

      for (int n = 0; n < 300; n++) rastgele_islem();

      repeat (5) @(negedge clk);
      kontrol("bekleyen_sonuc", 32'(q_sonuc.size()), 32'd0);
      kontrol("bekleyen_yazma", 32'(q_yaz.size()), 32'd0);
      $display("%0d/%0d checks passed", n_gecen, n_top);
      $finish;
   end

endmodule
